// File: rtl/core_sequencer_if.sv
// Instruction/data memory request-acknowledge bundle for core_sequencer.
// The sequencer is the master; the memories respond through the slave side.
interface core_sequencer_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ack,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ack,
      output dmem_ack
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM for the RV32I core.
// Define SEQ_TIMEOUT_EN to add the memory-acknowledge timeout and ERROR state.
module core_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   core_sequencer_if.master mem,
   input  logic             is_store,
   input  logic             is_load,
   input  logic             is_branch,
   input  logic             is_jump,
   input  logic             is_alu,
   input  logic             halt_req,
   output logic             decode_en,
   output logic             execute_en,
   output logic             wb_en,
   output logic             pc_we,
   output logic             retire,
   output logic [31:0]      instret,
   output logic             halted,
   output logic             bus_error
);

   typedef enum logic [2:0] {
      BOOT    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      MEM     = 3'd4,
      WB      = 3'd5,
      HALT    = 3'd6,
      ERROR   = 3'd7
   } state_e;

   state_e      state_q, state_d;
   logic        mem_q, mem_d;
   logic        store_q, store_d;
   logic        wr_q, wr_d;
   logic        hpend_q, hpend_d;
   logic [31:0] instret_q, instret_d;
   logic        tmo;

`ifdef SEQ_TIMEOUT_EN
   localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wcnt_q, wcnt_d;

   // Counter is zero in the first cycle of a wait, so the limit-th
   // waiting cycle without an ack is the last one tolerated.
   assign tmo = (wcnt_q >= WaitLimit);

   always_comb begin
      wcnt_d = '0;
      if ((state_q == FETCH && !mem.imem_ack) ||
          (state_q == MEM && !mem.dmem_ack))
         wcnt_d = wcnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) wcnt_q <= '0;
      else       wcnt_q <= wcnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BOOT;
         mem_q     <= 1'b0;
         store_q   <= 1'b0;
         wr_q      <= 1'b0;
         hpend_q   <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         mem_q     <= mem_d;
         store_q   <= store_d;
         wr_q      <= wr_d;
         hpend_q   <= hpend_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_d     = mem_q;
      store_d   = store_q;
      wr_d      = wr_q;
      hpend_d   = hpend_q;
      instret_d = instret_q;
      if (halt_req && state_q != HALT)
         hpend_d = 1'b1;
      unique case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (mem.imem_ack) state_d = DECODE;
            else if (tmo)     state_d = ERROR;
         end
         DECODE: state_d = EXECUTE;
         EXECUTE: begin
            mem_d   = 1'b0;
            store_d = 1'b0;
            wr_d    = 1'b0;
            priority case (1'b1)
               is_store: begin
                  mem_d   = 1'b1;
                  store_d = 1'b1;
               end
               is_load: begin
                  mem_d = 1'b1;
                  wr_d  = 1'b1;
               end
               is_branch: ;
               is_jump:   wr_d = 1'b1;
               is_alu:    wr_d = 1'b1;
               default:   ;
            endcase
            state_d = mem_d ? MEM : WB;
         end
         MEM: begin
            if (mem.dmem_ack) state_d = WB;
            else if (tmo)     state_d = ERROR;
         end
         WB: begin
            instret_d = instret_q + 32'd1;
            if (hpend_q || halt_req) begin
               state_d = HALT;
               hpend_d = 1'b0;
            end else begin
               state_d = FETCH;
            end
         end
         HALT: begin
            if (!halt_req) state_d = FETCH;
         end
`ifdef SEQ_TIMEOUT_EN
         ERROR: state_d = ERROR;
`else
         default: state_d = BOOT;
`endif
      endcase
   end

   // Strobes decode the state register; reset forces them quiet.
   always_comb begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      decode_en    = 1'b0;
      execute_en   = 1'b0;
      wb_en        = 1'b0;
      pc_we        = 1'b0;
      retire       = 1'b0;
      halted       = 1'b0;
      bus_error    = 1'b0;
      if (!reset) begin
         unique case (state_q)
            FETCH:   mem.imem_req = 1'b1;
            DECODE:  decode_en = 1'b1;
            EXECUTE: execute_en = 1'b1;
            MEM: begin
               mem.dmem_req = mem_q;
               mem.dmem_we  = store_q;
            end
            WB: begin
               pc_we  = 1'b1;
               retire = 1'b1;
               wb_en  = wr_q;
            end
            HALT:    halted = 1'b1;
`ifdef SEQ_TIMEOUT_EN
            ERROR:   bus_error = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   assign instret = instret_q;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the single-issue RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It generates one-cycle enables for the execute stage and register file, and handshakes with the instruction and data memories. It also applies halt requests at instruction boundaries and counts retired instructions.

## Interface
- TIMEOUT_CYCLES, default 255: maximum number of cycles to wait for a memory acknowledge. Used only when SEQ_TIMEOUT_EN is defined.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imem_req  out  1  instruction fetch request, held until acknowledged
- imem_ack  in  1  instruction memory done; instruction word valid this cycle
- is_store, is_load, is_branch, is_jump, is_alu  in  1 each  decoded instruction class, valid in EXECUTE
- dmem_req  out  1  data access request, held until acknowledged
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
- dmem_ack  in  1  data access done
- decode_en  out  1  decode stage captures the instruction word
- execute_en  out  1  execute stage clock enable
- wb_en  out  1  register file write strobe
- pc_we  out  1  PC register loads execute's next_pc
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction counter
- halt_req  in  1  debug halt request, level-sensitive
- halted  out  1  core is parked in HALT
- bus_error  out  1  sticky memory timeout flag

## Operation
- State encodings: BOOT=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, ERROR=7.
- All control outputs are combinational decodes of the state register. The exception is `instret`, which is a register.
- BOOT: all outputs are 0. Next state is always FETCH.
- FETCH: `imem_req`=1. Stay in FETCH until `imem_ack`=1, then go to DECODE.
- DECODE: `decode_en`=1 for one cycle. Next state is EXECUTE.
- EXECUTE: `execute_en`=1 for one cycle. The instruction class is latched into internal flags `mem`, `store` and `wr`.
  - Class priority when several class inputs are high: store > load > branch > jump > alu.
  - `mem` = store | load.
  - `wr` = load | jump | alu.
  - Next state is MEM if `mem`=1, otherwise WB.
  - If no class input is high, the instruction is treated as a NOP: `wr`=0, next state WB.
- MEM: `dmem_req`=1 and `dmem_we`=latched `store`. Stay in MEM until `dmem_ack`=1, then go to WB.
- WB actions:
  - `pc_we`=1 and `retire`=1.
  - `wb_en`=`wr`.
  - `instret` increments by 1, wrapping 0xFFFFFFFF→0.
- WB next state: HALT if a halt is pending, otherwise FETCH.
- Halt pending:
  - Set when `halt_req`=1 in any state other than HALT.
  - Also set when `halt_req`=1 in the WB cycle itself.
  - Cleared on entering HALT.
- HALT: `halted`=1 and all other strobes are 0. When `halt_req`=0, the next state is FETCH.
- Acknowledges are ignored in any state where the matching request is low.
- Reset mid-instruction: the next state is BOOT. Any outstanding memory transaction is abandoned and late acks are ignored. The halt-pending flag and the timeout counter clear. `instret` resets to 0.

## Timing
- Reset values: state=BOOT, `instret`=0, `bus_error`=0. Every output is 0 during and one cycle after reset.
- An ack in the first cycle of FETCH or MEM is accepted, so a memory with zero wait states costs one cycle.
- Instruction latency with zero-wait memories:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load or store: 5 cycles.
- Each memory wait cycle adds one cycle of latency.
- `retire` and the increment of `instret` occur on the same edge. `instret` shows the new value one cycle after the WB cycle.
- Halt latency: HALT is entered on the edge that ends the current instruction's WB.
- Release latency: FETCH is entered one cycle after `halt_req` is sampled low in HALT.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entering FETCH or MEM and increments each cycle without an ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack, the next state is ERROR.
  - ERROR sets `bus_error`=1, and `bus_error` stays 1. ERROR drives all strobes 0 and is exited only by reset.
  - An ack that arrives in the same cycle the limit is reached wins, and no error is raised.
- SEQ_TIMEOUT_EN undefined:
  - No counter and no ERROR state; FETCH and MEM wait indefinitely.
  - `bus_error` is tied to 0.

## Test plan
- Reset, then `imem_ack` held 1 with `is_alu`=1 for 3 instructions:
  - Expected: `retire` pulses on cycles 5, 9 and 13 after reset deasserts.
  - Expected: `instret`=3 and `wb_en` pulses 3 times.
- Load with `imem_ack` after 2 waits and `dmem_ack` after 3 waits:
  - Expected: the instruction takes 10 cycles.
  - Expected: `dmem_we`=0 throughout MEM, and `wb_en`=1 in WB.
- Store, then branch:
  - Expected for the store: `dmem_we`=1 and `wb_en`=0.
  - Expected for the branch: no MEM visit, `wb_en`=0, `pc_we`=1.
- `halt_req` pulsed for 1 cycle during DECODE:
  - Expected: the instruction completes, then `halted`=1.
  - Expected: FETCH follows on the next cycle, since `halt_req` is already low.
  - With `halt_req` held: stays in HALT, `imem_req`=0.
- Reset asserted during MEM, with `dmem_ack`=1 on the first cycle after BOOT:
  - Expected: no `wb_en`, and `instret`=0.
  - Expected: the next `imem_req` is seen on cycle 2.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - `imem_ack` never asserted: `bus_error`=1 after the 4th FETCH cycle and stays 1 until reset.
  - `imem_ack` arriving on the 4th cycle: no error is raised.
